// File: rtl/pipe_stage_fifo.sv
// Pipeline-stage FIFO with registered head output, flush squash and optional stall counter.
// Define PIPE_STAGE_FIFO_PERF_EN to build the back-pressure counter behind stall_cnt.
module pipe_stage_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              stall_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             push;
    logic             pop;

    // Ready/valid depend only on occupancy, never on the other side's handshake.
    assign in_ready  = (count != LW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign out_data  = mem[rd_ptr];
    assign level     = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

`ifdef PIPE_STAGE_FIFO_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (in_valid && !in_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: DEPTH=4 and DEPTH=2 instances, vector table, corner sequences, random vs queue model.
module tb_pipe_stage_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

`ifdef PIPE_STAGE_FIFO_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        flush4, in_valid4, in_ready4, out_valid4, out_ready4;
    logic [7:0]  in_data4, out_data4;
    logic [2:0]  level4;
    logic [31:0] stall4;

    logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2;
    logic [7:0]  in_data2, out_data2;
    logic [1:0]  level2;
    logic [31:0] stall2;

    pipe_stage_fifo #(.WIDTH(8), .DEPTH(4)) u_fifo4 (
        .clk(clk), .rst(rst), .flush(flush4),
        .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready4),
        .level(level4), .stall_cnt(stall4)
    );

    pipe_stage_fifo #(.WIDTH(8), .DEPTH(2)) u_fifo2 (
        .clk(clk), .rst(rst), .flush(flush2),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2),
        .level(level2), .stall_cnt(stall2)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        int         lvl;
        logic       ov;
        logic [7:0] od;
        logic       chk_od;
        logic       ir;
    } vec_t;

    vec_t tbl[10];

    logic [7:0] model_q[$];
    int         model_stall;
    int         n;

    initial begin
        // Fill then drain a DEPTH=4 FIFO, including a refused push when full and a pop when empty.
        tbl[0] = '{1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b1, 8'h11, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 8'h22, 1'b0, 2, 1'b1, 8'h11, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 8'h33, 1'b0, 3, 1'b1, 8'h11, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 8'h44, 1'b0, 4, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h55, 1'b0, 4, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 3, 1'b1, 8'h22, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h33, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h44, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b1};

        rst = 1'b0;
        flush4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
        flush2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid4), 32'd0);
        check("reset_level",     32'(level4),     32'd0);
        check("reset_in_ready",  32'(in_ready4),  32'd1);
        check("reset_stall",     stall4,          32'd0);
        check("reset_level2",    32'(level2),     32'd0);
        tick; tick;
        #2 rst = 1'b1;
        tick;

        for (int i = 0; i < 10; i++) begin
            flush4 = tbl[i].fl; in_valid4 = tbl[i].iv; in_data4 = tbl[i].d; out_ready4 = tbl[i].ordy;
            tick;
            check($sformatf("tbl%0d_level", i),     32'(level4),     32'(tbl[i].lvl));
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid4), 32'(tbl[i].ov));
            check($sformatf("tbl%0d_in_ready", i),  32'(in_ready4),  32'(tbl[i].ir));
            if (tbl[i].chk_od)
                check($sformatf("tbl%0d_out_data", i), 32'(out_data4), 32'(tbl[i].od));
        end
        in_valid4 = 1'b0; out_ready4 = 1'b0;

        // Full DEPTH=2 with push and pop together: pop only, push accepted next cycle.
        in_valid2 = 1'b1; in_data2 = 8'hA1; tick;
        in_data2 = 8'hA2; tick;
        check("full2_level",    32'(level2),    32'd2);
        check("full2_in_ready", 32'(in_ready2), 32'd0);
        in_data2 = 8'hA3; out_ready2 = 1'b1; tick;
        check("fullpop_level", 32'(level2),    32'd1);
        check("fullpop_data",  32'(out_data2), 32'hA2);
        out_ready2 = 1'b0; tick;
        check("fullpop_push_level", 32'(level2), 32'd2);
        in_valid2 = 1'b0; out_ready2 = 1'b1; tick;
        check("fullpop_push_data", 32'(out_data2), 32'hA3);
        tick;
        check("fullpop_empty", 32'(out_valid2), 32'd0);
        out_ready2 = 1'b0;

        // Continuous streaming through DEPTH=4 wraps both pointers.
        in_valid4 = 1'b1; out_ready4 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data4 = 8'(k);
            tick;
            check($sformatf("wrap%0d_level", k), 32'(level4),    32'd1);
            check($sformatf("wrap%0d_data", k),  32'(out_data4), 32'(k));
        end
        in_valid4 = 1'b0;
        tick;
        check("wrap_drained", 32'(level4), 32'd0);
        out_ready4 = 1'b0;

        // Flush beats a simultaneous push and pop.
        in_valid4 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data4 = 8'hC0 + 8'(k);
            tick;
        end
        check("preflush_level", 32'(level4), 32'd3);
        flush4 = 1'b1; in_data4 = 8'hEE; out_ready4 = 1'b1;
        tick;
        check("flush_level",     32'(level4),     32'd0);
        check("flush_out_valid", 32'(out_valid4), 32'd0);
        flush4 = 1'b0; in_valid4 = 1'b0;
        tick;
        check("postflush_out_valid", 32'(out_valid4), 32'd0);
        out_ready4 = 1'b0; in_valid4 = 1'b1; in_data4 = 8'h5A;
        tick;
        check("postflush_data", 32'(out_data4), 32'h5A);
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        tick;
        out_ready4 = 1'b0;

        // Asynchronous reset between edges with entries held.
        in_valid4 = 1'b1; in_data4 = 8'h61; tick;
        in_data4 = 8'h62; tick;
        in_valid4 = 1'b0;
        check("prereset_level", 32'(level4), 32'd2);
        #2 rst = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid4), 32'd0);
        check("async_level",     32'(level4),     32'd0);
        check("async_in_ready",  32'(in_ready4),  32'd1);
        check("async_stall",     stall4,          32'd0);
        #1 rst = 1'b1;
        in_valid4 = 1'b1; in_data4 = 8'h77;
        tick;
        in_valid4 = 1'b0;
        check("after_reset_data",  32'(out_data4), 32'h77);
        check("after_reset_level", 32'(level4),    32'd1);

        // Back-pressure counter on DEPTH=2 from empty; flush must not clear it.
        in_valid2 = 1'b1; out_ready2 = 1'b0; in_data2 = 8'h90;
        for (int k = 0; k < 7; k++) tick;
        in_valid2 = 1'b0;
        check("perf_level", 32'(level2), 32'd2);
        check("perf_stall", stall2, PERF ? 32'd5 : 32'd0);
        flush2 = 1'b1;
        tick;
        flush2 = 1'b0;
        check("perf_flush_level", 32'(level2), 32'd0);
        check("perf_flush_stall", stall2, PERF ? 32'd5 : 32'd0);

        // Random traffic on DEPTH=4 against a queue model.
        model_q = {};
        model_q.push_back(8'h77);
        model_stall = 0;
        for (int i = 0; i < 600; i++) begin
            flush4     = ($urandom_range(0, 39) == 0);
            in_valid4  = ($urandom_range(0, 3) != 0);
            in_data4   = 8'($urandom);
            out_ready4 = ((i / 60) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            n = model_q.size();
            if (in_valid4 && n == 4) model_stall++;
            if (flush4) begin
                model_q = {};
            end else begin
                if (out_ready4 && n > 0) void'(model_q.pop_front());
                if (in_valid4 && n < 4) model_q.push_back(in_data4);
            end
            tick;
            check("rand_level",     32'(level4),     32'(model_q.size()));
            check("rand_out_valid", 32'(out_valid4), 32'(model_q.size() != 0));
            check("rand_in_ready",  32'(in_ready4),  32'(model_q.size() != 4));
            if (model_q.size() != 0)
                check("rand_out_data", 32'(out_data4), 32'(model_q[0]));
            check("rand_stall", stall4, PERF ? 32'(model_stall) : 32'd0);
        end
        flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
